// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and the occupancy-count width helper for sync_fifo_param.
package fifo_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: write/read handshake and status bundle; error flags exist only with FIFO_ERR_FLAGS_EN.
interface sync_fifo_param_if import fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  logic wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic o_fifo_full;
  logic o_fifo_empty;
  logic o_fifo_almost_full;
  logic o_fifo_almost_empty;
  logic [cnt_w(DEPTH)-1:0] o_fifo_count;
`ifdef FIFO_ERR_FLAGS_EN
  logic o_overflow;
  logic o_underflow;
`endif
  modport master (
    output wr_en, wr_data, rd_en,
    input rd_data, o_fifo_full, o_fifo_empty, o_fifo_almost_full, o_fifo_almost_empty, o_fifo_count
`ifdef FIFO_ERR_FLAGS_EN
    , input o_overflow, o_underflow
`endif
  );
  modport slave (
    input wr_en, wr_data, rd_en,
    output rd_data, o_fifo_full, o_fifo_empty, o_fifo_almost_full, o_fifo_almost_empty, o_fifo_count
`ifdef FIFO_ERR_FLAGS_EN
    , output o_overflow, o_underflow
`endif
  );
endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port storage, synchronous write, registered read word that holds when not read.
module fifo_mem #(
  parameter int DW = 8,
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q, rdata_d;
  always_comb rdata_d = re ? mem[raddr] : rdata_q;
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk) rdata_q <= rst ? '0 : rdata_d;
  assign rdata = rdata_q;
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: synchronous FIFO control and status flags; storage lives in fifo_mem.
// Define FIFO_ERR_FLAGS_EN to add sticky o_overflow/o_underflow outputs.
module sync_fifo_param import fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
)(
  input logic clk,
  input logic rst,
  sync_fifo_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wr_ok, rd_ok, full, empty;
  always_comb begin
    full = cnt_q == CW'(DEPTH);
    empty = cnt_q == '0;
    rd_ok = bus.rd_en && !empty;
    wr_ok = bus.wr_en && (!full || rd_ok);
    wptr_d = wr_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d = rd_ok ? rptr_q + 1'b1 : rptr_q;
    cnt_d = (wr_ok && !rd_ok) ? cnt_q + 1'b1 : (rd_ok && !wr_ok) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.o_fifo_full = full;
  assign bus.o_fifo_empty = empty;
  assign bus.o_fifo_almost_full = cnt_q >= CW'(AF_THRESH);
  assign bus.o_fifo_almost_empty = cnt_q <= CW'(AE_THRESH);
  assign bus.o_fifo_count = cnt_q;
  fifo_mem #(.DW(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .rst(rst),
    .we(wr_ok),
    .waddr(wptr_q),
    .wdata(bus.wr_data),
    .re(rd_ok),
    .raddr(rptr_q),
    .rdata(bus.rd_data)
  );
`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d, unf_q, unf_d;
  always_comb begin
    ovf_d = ovf_q || (bus.wr_en && !wr_ok);
    unf_d = unf_q || (bus.rd_en && !rd_ok);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  assign bus.o_overflow = ovf_q;
  assign bus.o_underflow = unf_q;
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: vector table plus queue scoreboard for sync_fifo_param at default parameters.
module tb_sync_fifo_param;
  localparam int DEPTH = 16;
  localparam int AF = DEPTH - 2;
  localparam int AE = 2;
  typedef struct {
    logic r;
    logic w;
    logic [7:0] d;
    logic rd;
    int cnt;
    logic [7:0] q;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sb[$];
  logic [7:0] m_q = 8'h00;
  logic m_ovf = 1'b0;
  logic m_unf = 1'b0;
  vec_t tbl[10];
  sync_fifo_param_if #(.DATA_WIDTH(8), .DEPTH(DEPTH)) bus ();
  sync_fifo_param dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic w, input logic [7:0] d, input logic rd);
    bit rok, wok;
    int c;
    rst = r;
    bus.wr_en = w;
    bus.wr_data = d;
    bus.rd_en = rd;
    if (r) begin
      sb.delete();
      m_q = 8'h00;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      rok = rd && sb.size() > 0;
      wok = w && (sb.size() < DEPTH || rok);
      if (rok) m_q = sb.pop_front();
      if (wok) sb.push_back(d);
      m_ovf = m_ovf | (w & !wok);
      m_unf = m_unf | (rd & !rok);
    end
    @(posedge clk);
    #1;
    c = sb.size();
    chk("count", 32'(bus.o_fifo_count), 32'(c));
    chk("empty", 32'(bus.o_fifo_empty), 32'(c == 0));
    chk("full", 32'(bus.o_fifo_full), 32'(c == DEPTH));
    chk("almost_empty", 32'(bus.o_fifo_almost_empty), 32'(c <= AE));
    chk("almost_full", 32'(bus.o_fifo_almost_full), 32'(c >= AF));
    chk("rd_data", 32'(bus.rd_data), 32'(m_q));
`ifdef FIFO_ERR_FLAGS_EN
    chk("overflow", 32'(bus.o_overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.o_underflow), 32'(m_unf));
`endif
    rst = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask
  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.wr_data = 8'h00;
    tbl[0] = '{1'b1, 1'b1, 8'hFF, 1'b1, 0, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 8'h34, 1'b0, 1, 8'h00};
    tbl[2] = '{1'b0, 1'b1, 8'h28, 1'b0, 2, 8'h00};
    tbl[3] = '{1'b0, 1'b1, 8'hAB, 1'b0, 3, 8'h00};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 2, 8'h34};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 8'h28};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 8'hAB};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 8'hAB};
    tbl[8] = '{1'b0, 1'b1, 8'h55, 1'b1, 1, 8'hAB};
    tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 8'h55};
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].r, tbl[i].w, tbl[i].d, tbl[i].rd);
      chk($sformatf("tbl%0d_count", i), 32'(bus.o_fifo_count), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_rd_data", i), 32'(bus.rd_data), 32'(tbl[i].q));
    end
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0);
      chk($sformatf("fill%0d_af", i), 32'(bus.o_fifo_almost_full), 32'(i + 1 >= 14));
    end
    chk("fill_full", 32'(bus.o_fifo_full), 32'd1);
    step(1'b0, 1'b1, 8'h99, 1'b0);
    chk("drop_count", 32'(bus.o_fifo_count), 32'd16);
    step(1'b0, 1'b1, 8'hEE, 1'b1);
    chk("full_rw_count", 32'(bus.o_fifo_count), 32'd16);
    chk("full_rw_rd_data", 32'(bus.rd_data), 32'h00);
    for (int i = 1; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      chk($sformatf("drain%0d", i), 32'(bus.rd_data), 32'(i));
    end
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("last_is_ee", 32'(bus.rd_data), 32'hEE);
    chk("drained_empty", 32'(bus.o_fifo_empty), 32'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'(8'hA0 + i), i[0]);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b1);
    chk("rst_count", 32'(bus.o_fifo_count), 32'd0);
    chk("rst_empty", 32'(bus.o_fifo_empty), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("post_rst_rd_data", 32'(bus.rd_data), 32'h00);
    chk("post_rst_count", 32'(bus.o_fifo_count), 32'd0);
    step(1'b0, 1'b1, 8'h3C, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("post_rst_read", 32'(bus.rd_data), 32'h3C);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
